// File: rtl/bip_control_unit_if.sv
// Control-unit signal bundle between bip_control_unit (master) and the datapath (slave).
// ctrl_illegal_op exists only when BIP_ILLEGAL_TRAP_EN is defined.
interface bip_control_unit_if #(
  parameter int OPCODE_WIDTH = 5
);
  logic [OPCODE_WIDTH-1:0] ctrl_opcode;
  logic                    ctrl_flag_Z;
  logic                    ctrl_flag_N;
  logic                    ctrl_mem_ready;
  logic                    ctrl_ir_wr;
  logic                    ctrl_pc_wr;
  logic                    ctrl_pc_src;
  logic                    ctrl_acc_wr;
  logic [1:0]              ctrl_acc_src;
  logic                    ctrl_alu_op;
  logic                    ctrl_alu_src_b;
  logic                    ctrl_flags_wr;
  logic                    ctrl_mem_rd;
  logic                    ctrl_mem_wr;
  logic                    ctrl_addr_src;
  logic                    ctrl_halted;
  logic                    ctrl_bus_error;
`ifdef BIP_ILLEGAL_TRAP_EN
  logic                    ctrl_illegal_op;
`endif

  modport master (
    input  ctrl_opcode, ctrl_flag_Z, ctrl_flag_N, ctrl_mem_ready,
    output ctrl_ir_wr, ctrl_pc_wr, ctrl_pc_src, ctrl_acc_wr, ctrl_acc_src,
           ctrl_alu_op, ctrl_alu_src_b, ctrl_flags_wr, ctrl_mem_rd,
           ctrl_mem_wr, ctrl_addr_src, ctrl_halted, ctrl_bus_error
`ifdef BIP_ILLEGAL_TRAP_EN
    , output ctrl_illegal_op
`endif
  );

  modport slave (
    output ctrl_opcode, ctrl_flag_Z, ctrl_flag_N, ctrl_mem_ready,
    input  ctrl_ir_wr, ctrl_pc_wr, ctrl_pc_src, ctrl_acc_wr, ctrl_acc_src,
           ctrl_alu_op, ctrl_alu_src_b, ctrl_flags_wr, ctrl_mem_rd,
           ctrl_mem_wr, ctrl_addr_src, ctrl_halted, ctrl_bus_error
`ifdef BIP_ILLEGAL_TRAP_EN
    , input ctrl_illegal_op
`endif
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP accumulator-CPU control FSM (FETCH/DECODE/EXECUTE/HALT) with a memory-ready watchdog.
// Define BIP_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT and expose ctrl_illegal_op.
module bip_control_unit #(
  parameter int OPCODE_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                clock,
  input logic                control_reset,
  bip_control_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(5'd0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(5'd1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(5'd2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(5'd3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(5'd4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5'd5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(5'd6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(5'd7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(5'd8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(5'd9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(5'd10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(5'd11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(5'd12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(5'd13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(5'd14);

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_inc_s;
  logic       bus_error_r;
  logic       mem_op_s;
  logic       taken_s;
  logic       undef_op_s;
  logic       waiting_s;
  logic       timeout_s;

  assign undef_op_s = (bus.ctrl_opcode > OP_JMP);
  assign waiting_s  = (state_r == ST_FETCH) || ((state_r == ST_EXECUTE) && mem_op_s);
  assign wait_inc_s = wait_cnt_r + 8'd1;
  // Timeout fires on the wait cycle that would bring the counter up to TIMEOUT_CYCLES.
  assign timeout_s  = waiting_s && !bus.ctrl_mem_ready && (wait_inc_s == 8'(TIMEOUT_CYCLES));

  // Opcode classification: memory-access ops and branch condition evaluation.
  always_comb begin
    mem_op_s = 1'b0;
    taken_s  = 1'b0;
    case (bus.ctrl_opcode)
      OP_STO, OP_LD, OP_ADD, OP_SUB: mem_op_s = 1'b1;
      OP_BEQ: taken_s = bus.ctrl_flag_Z;
      OP_BNE: taken_s = !bus.ctrl_flag_Z;
      OP_BGT: taken_s = !bus.ctrl_flag_Z && !bus.ctrl_flag_N;
      OP_BGE: taken_s = !bus.ctrl_flag_N;
      OP_BLT: taken_s = bus.ctrl_flag_N;
      OP_BLE: taken_s = bus.ctrl_flag_N || bus.ctrl_flag_Z;
      OP_JMP: taken_s = 1'b1;
      default: begin
        mem_op_s = 1'b0;
        taken_s  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge control_reset) begin
    if (!control_reset) state_r <= ST_FETCH;
    else                state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (timeout_s)               next_state_s = ST_HALT;
        else if (bus.ctrl_mem_ready) next_state_s = ST_DECODE;
        else                         next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (bus.ctrl_opcode == OP_HLT) next_state_s = ST_HALT;
`ifdef BIP_ILLEGAL_TRAP_EN
        else if (undef_op_s)           next_state_s = ST_HALT;
`endif
        else                           next_state_s = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (timeout_s)                          next_state_s = ST_HALT;
        else if (!mem_op_s || bus.ctrl_mem_ready) next_state_s = ST_FETCH;
        else                                    next_state_s = ST_EXECUTE;
      end
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Handshake wait counter and sticky bus error.
  always_ff @(posedge clock or negedge control_reset) begin
    if (!control_reset) begin
      wait_cnt_r  <= 8'd0;
      bus_error_r <= 1'b0;
    end else begin
      if (waiting_s && !bus.ctrl_mem_ready && !timeout_s) wait_cnt_r <= wait_inc_s;
      else                                                wait_cnt_r <= 8'd0;
      if (timeout_s) bus_error_r <= 1'b1;
      else           bus_error_r <= bus_error_r;
    end
  end

`ifdef BIP_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky undefined-opcode flag, captured as the FSM leaves DECODE.
  always_ff @(posedge clock or negedge control_reset) begin
    if (!control_reset)                             illegal_r <= 1'b0;
    else if ((state_r == ST_DECODE) && undef_op_s)  illegal_r <= 1'b1;
    else                                            illegal_r <= illegal_r;
  end

  assign bus.ctrl_illegal_op = illegal_r;
`endif

  // Output decode: Moore strobes per state, completion strobes qualified by ready on memory ops.
  always_comb begin
    bus.ctrl_ir_wr     = 1'b0;
    bus.ctrl_pc_wr     = 1'b0;
    bus.ctrl_pc_src    = 1'b0;
    bus.ctrl_acc_wr    = 1'b0;
    bus.ctrl_acc_src   = 2'b00;
    bus.ctrl_alu_op    = 1'b0;
    bus.ctrl_alu_src_b = 1'b0;
    bus.ctrl_flags_wr  = 1'b0;
    bus.ctrl_mem_rd    = 1'b0;
    bus.ctrl_mem_wr    = 1'b0;
    bus.ctrl_addr_src  = 1'b0;
    bus.ctrl_halted    = 1'b0;
    bus.ctrl_bus_error = 1'b0;
    if (control_reset) begin
      bus.ctrl_bus_error = bus_error_r;
      case (state_r)
        ST_FETCH: begin
          bus.ctrl_mem_rd = 1'b1;
          bus.ctrl_ir_wr  = bus.ctrl_mem_ready;
        end
        ST_DECODE: bus.ctrl_mem_rd = 1'b0;
        ST_EXECUTE: begin
          case (bus.ctrl_opcode)
            OP_STO: begin
              bus.ctrl_mem_wr   = 1'b1;
              bus.ctrl_addr_src = 1'b1;
              bus.ctrl_pc_wr    = bus.ctrl_mem_ready;
            end
            OP_LD: begin
              bus.ctrl_mem_rd   = 1'b1;
              bus.ctrl_addr_src = 1'b1;
              bus.ctrl_acc_src  = 2'b01;
              bus.ctrl_acc_wr   = bus.ctrl_mem_ready;
              bus.ctrl_pc_wr    = bus.ctrl_mem_ready;
            end
            OP_LDI: begin
              bus.ctrl_acc_src = 2'b10;
              bus.ctrl_acc_wr  = 1'b1;
              bus.ctrl_pc_wr   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ctrl_mem_rd   = 1'b1;
              bus.ctrl_addr_src = 1'b1;
              bus.ctrl_alu_op   = (bus.ctrl_opcode == OP_SUB);
              bus.ctrl_acc_wr   = bus.ctrl_mem_ready;
              bus.ctrl_flags_wr = bus.ctrl_mem_ready;
              bus.ctrl_pc_wr    = bus.ctrl_mem_ready;
            end
            OP_ADDI, OP_SUBI: begin
              bus.ctrl_alu_src_b = 1'b1;
              bus.ctrl_alu_op    = (bus.ctrl_opcode == OP_SUBI);
              bus.ctrl_acc_wr    = 1'b1;
              bus.ctrl_flags_wr  = 1'b1;
              bus.ctrl_pc_wr     = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
              bus.ctrl_pc_wr  = 1'b1;
              bus.ctrl_pc_src = taken_s;
            end
            default: bus.ctrl_pc_wr = undef_op_s;
          endcase
        end
        ST_HALT: bus.ctrl_halted = 1'b1;
        default: bus.ctrl_halted = 1'b0;
      endcase
    end else begin
      bus.ctrl_halted = 1'b0;
    end
  end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Multi-cycle control FSM for the BIP-style accumulator CPU. Instruction format is a 5-bit opcode plus an 11-bit operand.
- Sits directly downstream of the Z/N flags register: consumes flag_Z/flag_N for conditional branches.
- Drives that register's write enable, plus every PC, IR, ACC, ALU and memory strobe in the datapath.
- Includes a memory-ready handshake with a timeout watchdog.

Parameters:
- OPCODE_WIDTH, 5, opcode field width.
- TIMEOUT_CYCLES, 15, maximum wait cycles for ctrl_mem_ready before bus error; legal range 1..255.

Ports:
- clock  input  1  system clock, rising edge.
- control_reset  input  1  asynchronous, active-low reset.
- ctrl_opcode  input  OPCODE_WIDTH  opcode field of the IR, valid from DECODE onward.
- ctrl_flag_Z  input  1  zero flag from the flags register.
- ctrl_flag_N  input  1  negative flag from the flags register.
- ctrl_mem_ready  input  1  memory has completed the current read/write this cycle.
- ctrl_ir_wr  output  1  load IR from memory data.
- ctrl_pc_wr  output  1  update PC.
- ctrl_pc_src  output  1  0 = PC+1, 1 = operand (branch target).
- ctrl_acc_wr  output  1  load accumulator.
- ctrl_acc_src  output  2  00 ALU, 01 memory data, 10 immediate.
- ctrl_alu_op  output  1  0 add, 1 subtract.
- ctrl_alu_src_b  output  1  0 memory data, 1 immediate.
- ctrl_flags_wr  output  1  write enable to the flags register.
- ctrl_mem_rd  output  1  memory read request.
- ctrl_mem_wr  output  1  memory write request.
- ctrl_addr_src  output  1  0 = PC addresses memory, 1 = operand.
- ctrl_halted  output  1  core stopped.
- ctrl_bus_error  output  1  sticky; set on handshake timeout.

Behaviour:
- States: FETCH, DECODE, EXECUTE, HALT. State register is 2 bits, Moore outputs except where noted.
- Reset: asynchronous, active-low. State goes to FETCH and the wait counter to 0. All outputs are 0 while reset is asserted, ctrl_halted and ctrl_bus_error included.
- FETCH: ctrl_mem_rd=1, ctrl_addr_src=0. Hold in FETCH until ctrl_mem_ready=1. On that cycle ctrl_ir_wr=1 (Mealy on ready), then go to DECODE.
- DECODE: 1 cycle, no strobes. HLT (00000) goes to HALT; all other opcodes go to EXECUTE.
- EXECUTE, per opcode:
  - STO 00001: mem_wr=1, addr_src=1; wait for ready.
  - LD 00010: mem_rd=1, addr_src=1, acc_src=01; wait for ready.
  - LDI 00011: acc_src=10, single cycle.
  - ADD 00100: mem_rd, alu_op=0, alu_src_b=0; wait for ready.
  - ADDI 00101: alu_op=0, alu_src_b=1, single cycle.
  - SUB 00110: as ADD with alu_op=1.
  - SUBI 00111: as ADDI with alu_op=1.
  - Branches use pc_src = taken:
    - BEQ 01000: Z.
    - BNE 01001: !Z.
    - BGT 01010: !Z & !N.
    - BGE 01011: !N.
    - BLT 01100: N.
    - BLE 01101: N | Z.
    - JMP 01110: 1.
- Completion: acc_wr, flags_wr (ADD/ADDI/SUB/SUBI only) and pc_wr pulse for exactly 1 cycle, on the ready cycle (memory ops) or the single EXECUTE cycle. Next state is FETCH.
- Flag timing: flags are sampled combinationally in EXECUTE. A flags_wr issued by the previous instruction is visible, because the flags register updates on that edge.
- Undefined opcodes 01111..11111 without the optional feature: NOP, pc_wr=1, pc_src=0.
- Wait counter:
  - Increments in every FETCH or memory-EXECUTE cycle with ctrl_mem_ready=0.
  - Clears on ready or on any state change.
  - When it reaches TIMEOUT_CYCLES: ctrl_bus_error=1 and the FSM goes to HALT; no write strobes issue.
- ctrl_mem_ready outside a waiting state is ignored.
- HALT is absorbing: ctrl_halted=1 and all other strobes 0; it is left only via reset.
- Reset mid-EXECUTE discards the instruction; no partial strobe survives.

Optional Feature:
- Macro BIP_ILLEGAL_TRAP_EN.
- When defined:
  - Undefined opcodes go from DECODE to HALT.
  - Adds output ctrl_illegal_op (1 bit), sticky and cleared only by reset.
  - PC is not incremented.
- When undefined: the port is absent and undefined opcodes execute as NOP.

Test Plan:
- Reset low, then high, with ready tied 1 and opcode LDI → FETCH(ir_wr) and DECODE follow, then EXECUTE asserts acc_wr=1, acc_src=10, pc_wr=1, pc_src=0. Loop period is 3 cycles.
- SUB with ready delayed 3 cycles → mem_rd held for 4 cycles. acc_wr, flags_wr and pc_wr each pulse once, only on the ready cycle, with alu_op=1.
- BEQ/BNE/BGT/BGE/BLT/BLE/JMP swept over all four {Z,N} combinations → pc_src matches the condition table (e.g. BLE with Z=0,N=0 gives 0, BGT with Z=0,N=0 gives 1). pc_wr=1 in every case.
- ready held 0 in FETCH with TIMEOUT_CYCLES=15 → bus_error=1 and halted=1 after 15 wait cycles. ir_wr is never asserted. Outputs stay until reset is pulled low.
- HLT opcode → halted=1 two cycles after the FETCH ready cycle. It remains 1 for 20 more cycles, then clears on async reset asserted mid-cycle.
- Opcode 10110 with BIP_ILLEGAL_TRAP_EN → illegal_op=1 and HALT, no pc_wr. Without the macro → pc_wr=1, pc_src=0, back to FETCH.
